// File: rtl/pipe_select_mux_pkg.sv
// Shared types and helpers for the pipe_select_mux block.
// Buffer state encoding and select-width calculation.
package pipe_select_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_select_mux_if.sv
// Upstream/downstream bundle for pipe_select_mux.
// slave is the block side, master the environment side.
interface pipe_select_mux_if #(
    parameter int NUM_INPUTS = 4,
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 32
);
    import pipe_select_mux_pkg::*;

    localparam int SEL_W = sel_width(NUM_INPUTS);

    logic [SEL_W-1:0]               sel;
    logic [NUM_INPUTS*IN_WIDTH-1:0] in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic                           flush;
    logic [OUT_WIDTH-1:0]           out_data;
    logic [SEL_W-1:0]               out_sel;
    logic                           out_valid;
    logic                           out_ready;
    logic                           sel_err;

    modport slave (
        input  sel, in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err
    );

    modport master (
        output sel, in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err
    );

endinterface

// File: rtl/pipe_select_mux_sel_extend.sv
// Channel pick plus sign/zero extension, shared by both load paths.
// An out-of-range select yields zero data and raises err_o.
module pipe_select_mux_sel_extend
    import pipe_select_mux_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int SIGN_EXT   = 1,
    parameter int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic [SEL_W-1:0]               sel_i,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] data_i,
    output logic [OUT_WIDTH-1:0]           data_o,
    output logic                           err_o
);

    logic [IN_WIDTH-1:0] chan;
    logic                fill;

    always_comb begin
        chan  = '0;
        err_o = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(sel_i) == k) begin
                chan  = data_i[k*IN_WIDTH +: IN_WIDTH];
                err_o = 1'b0;
            end
        end
        fill   = (SIGN_EXT != 0) && chan[IN_WIDTH-1];
        data_o = {OUT_WIDTH{fill}};
        data_o[IN_WIDTH-1:0] = chan;
    end

endmodule

// File: rtl/pipe_select_mux.sv
// Registered channel select with a two-entry skid buffer.
// Main register feeds the outputs; skid absorbs one stalled beat.
module pipe_select_mux
    import pipe_select_mux_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 32,
    parameter int SIGN_EXT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    pipe_select_mux_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_INPUTS);

    buf_state_e           state_q, state_d;
    logic [OUT_WIDTH-1:0] main_data_q, main_data_d;
    logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0]     main_sel_q, main_sel_d;
    logic [SEL_W-1:0]     skid_sel_q, skid_sel_d;
    logic                 in_ready_q, in_ready_d;
    logic                 sel_err_q, sel_err_d;
    logic [OUT_WIDTH-1:0] ext_data;
    logic                 ext_err;
    logic                 out_valid;
    logic                 in_xfer;
    logic                 out_xfer;

    pipe_select_mux_sel_extend #(
        .NUM_INPUTS (NUM_INPUTS),
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SIGN_EXT   (SIGN_EXT),
        .SEL_W      (SEL_W)
    ) u_sel_extend (
        .sel_i  (bus.sel),
        .data_i (bus.in_data),
        .data_o (ext_data),
        .err_o  (ext_err)
    );

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = bus.in_valid & in_ready_q & ~bus.flush;
    assign out_xfer  = out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        sel_err_d   = sel_err_q | (in_xfer & ext_err);
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_data_d = ext_data;
                    main_sel_d  = bus.sel;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = ext_data;
                    main_sel_d  = bus.sel;
                end else if (in_xfer) begin
                    skid_data_d = ext_data;
                    skid_sel_d  = bus.sel;
                    state_d     = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) begin
            state_d = EMPTY;
        end
        // Registered so in_ready never depends on same-cycle inputs.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;
    assign bus.sel_err   = sel_err_q;

endmodule
